ram_access_ctrl: RTL



---
 rtl/ram_access_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Sequencer for a 256x8 asynchronous RAM: setup / strobe / hold phasing on a valid/ready request port.
// Optional write-verify read-back is enabled by defining RAM_ACCESS_CTRL_VERIFY_EN.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reqValid,
  output logic                  o_reqReady,
  input  logic                  i_reqWrite,
  input  logic [ADDR_WIDTH-1:0] i_reqAddress,
  input  logic [DATA_WIDTH-1:0] i_reqWriteData,
  output logic                  o_rspValid,
  output logic [DATA_WIDTH-1:0] o_rspReadData,
  output logic [ADDR_WIDTH-1:0] o_ramAddress,
  output logic                  o_ramWriteEn,
  output logic [DATA_WIDTH-1:0] o_ramWriteData,
  input  logic [DATA_WIDTH-1:0] i_ramReadData,
  output logic                  o_ramNoe,
  output logic                  o_verifyError
);

  localparam int SP_MAX  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CNT_MAX = (SP_MAX > HOLD_CYCLES) ? SP_MAX : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_RELOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_CYCLES - 1);

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, VERIFY} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    we_q, we_d;
  logic                    noe_q, noe_d;
  logic                    verify_err_q, verify_err_d;
  logic                    phase_done;

  assign phase_done = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = phase_done ? cnt_q : cnt_q - CNT_W'(1);
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rsp_valid_d  = 1'b0;
    verify_err_d = verify_err_q;

    case (state_q)
      IDLE: begin
        if (i_reqValid) begin
          write_d = i_reqWrite;
          addr_d  = i_reqAddress;
          wdata_d = i_reqWriteData;
          state_d = SETUP;
          cnt_d   = SETUP_RELOAD;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_d = STROBE;
          cnt_d   = PULSE_RELOAD;
        end
      end
      STROBE: begin
        if (phase_done) begin
          if (!write_q) begin
            rdata_d = i_ramReadData;
          end
          state_d = HOLD;
          cnt_d   = HOLD_RELOAD;
        end
      end
      HOLD: begin
        if (phase_done) begin
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
          if (write_q) begin
            state_d = VERIFY;
            cnt_d   = PULSE_RELOAD;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
          end
`else
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
`endif
        end
      end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
      VERIFY: begin
        if (phase_done) begin
          if (i_ramReadData != wdata_q) begin
            verify_err_d = 1'b1;
          end
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin strobes are registered from the next state so the RAM sees clean, glitch-free edges.
    we_d  = (state_d == STROBE) && write_d;
    noe_d = 1'b1;
    if (!write_d && ((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD))) begin
      noe_d = 1'b0;
    end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    if (state_d == VERIFY) begin
      noe_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      noe_q        <= 1'b1;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      we_q         <= we_d;
      noe_q        <= noe_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign o_reqReady     = (state_q == IDLE);
  assign o_rspValid     = rsp_valid_q;
  assign o_rspReadData  = rdata_q;
  assign o_ramAddress   = addr_q;
  assign o_ramWriteData = wdata_q;
  assign o_ramWriteEn   = we_q;
  assign o_ramNoe       = noe_q;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
  assign o_verifyError  = verify_err_q;
`else
  assign o_verifyError  = 1'b0;
`endif

endmodule
